// File: rtl/fwd_pkg.sv
// rtl/fwd_pkg.sv - shared types, source encodings and width helper for the forwarding scoreboard
package fwd_pkg;

    typedef struct packed {
        logic       valid;
        logic [4:0] wreg;
        logic [1:0] readyStage;
    } sbEntry_t;

    // Source codes: 0 = register file, 1..DEPTH = stage index + 1, DEPTH+1 = MEM override
    localparam int SRC_GPR = 0;

    function automatic int srcWidth(input int depth);
        return $clog2(depth + 2);
    endfunction

endpackage

// File: rtl/fwd_lookup_port.sv
// rtl/fwd_lookup_port.sv - one operand port's priority match against the in-flight table
module fwd_lookup_port
    import fwd_pkg::*;
#(
    parameter int DEPTH  = 3,
    parameter int DATA_W = 32,
    parameter int SRC_W  = 3
) (
    input  sbEntry_t [DEPTH-1:0]        entries,
    input  logic     [DEPTH*DATA_W-1:0] stageResult,
    input  logic     [4:0]              reqReg,
    input  logic                        needNow,
    input  logic     [DATA_W-1:0]       gprData,
    output logic     [DATA_W-1:0]       fwdData,
    output logic     [SRC_W-1:0]        fwdSrc,
    output logic                        stallReq
);

    // Scan oldest to youngest so the youngest (lowest index) producer wins.
    always_comb begin
        fwdData  = gprData;
        fwdSrc   = SRC_W'(SRC_GPR);
        stallReq = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (entries[i].valid && (entries[i].wreg == reqReg) && (reqReg != 5'd0)) begin
                fwdData  = stageResult[i*DATA_W +: DATA_W];
                fwdSrc   = SRC_W'(i + 1);
                stallReq = needNow && (i < int'(entries[i].readyStage));
            end
        end
    end

endmodule

// File: rtl/forwarding_scoreboard.sv
// rtl/forwarding_scoreboard.sv - operand forwarding scoreboard with MDU interlock; optional FWD_MEM_OVERRIDE_EN
module forwarding_scoreboard
    import fwd_pkg::*;
#(
    parameter  int NUM_PORTS = 2,
    parameter  int DEPTH     = 3,
    parameter  int DATA_W    = 32,
    localparam int SRC_W     = srcWidth(DEPTH)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          advance,
    input  logic                          issue_valid,
    input  logic [4:0]                    issue_wreg,
    input  logic [1:0]                    issue_ready_stage,
    input  logic                          flush,
    input  logic [DEPTH*DATA_W-1:0]       stage_result,
    input  logic [NUM_PORTS*5-1:0]        req_reg,
    input  logic [NUM_PORTS-1:0]          req_need_now,
    input  logic [NUM_PORTS*DATA_W-1:0]   gpr_data,
    input  logic                          mdu_start,
    input  logic [5:0]                    mdu_cycles,
    input  logic                          mdu_read,
`ifdef FWD_MEM_OVERRIDE_EN
    input  logic [NUM_PORTS-1:0]          mem_fwd_en,
    input  logic [NUM_PORTS*DATA_W-1:0]   mem_fwd_data,
`endif
    output logic [NUM_PORTS*DATA_W-1:0]   fwd_data,
    output logic [NUM_PORTS*SRC_W-1:0]    fwd_src,
    output logic                          stall,
    output logic                          mdu_busy
);

    sbEntry_t [DEPTH-1:0] entries;
    sbEntry_t             loadEntry;
    logic [5:0]           mduCount;
    logic [NUM_PORTS-1:0] portStall;

    // A stalled ID becomes a bubble even when the pipe advances.
    always_comb begin
        loadEntry.valid      = issue_valid && !stall && !flush && (issue_wreg != 5'd0);
        loadEntry.wreg       = issue_wreg;
        loadEntry.readyStage = issue_ready_stage;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            entries <= '0;
        end else if (advance) begin
            for (int i = DEPTH - 1; i > 0; i--) begin
                entries[i] <= entries[i-1];
            end
            entries[0] <= loadEntry;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mduCount <= 6'd0;
        end else if (mdu_start && (mdu_cycles != 6'd0)) begin
            mduCount <= mdu_cycles;
        end else if (mduCount != 6'd0) begin
            mduCount <= mduCount - 6'd1;
        end
    end

    assign mdu_busy = !reset && (mduCount != 6'd0);
    assign stall    = !reset && ((|portStall) || (mdu_busy && mdu_read));

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        logic [DATA_W-1:0] lkData;
        logic [SRC_W-1:0]  lkSrc;
        logic              lkStall;
        logic [DATA_W-1:0] gprWord;

        assign gprWord = gpr_data[p*DATA_W +: DATA_W];

        fwd_lookup_port #(
            .DEPTH (DEPTH),
            .DATA_W(DATA_W),
            .SRC_W (SRC_W)
        ) uLookup (
            .entries    (entries),
            .stageResult(stage_result),
            .reqReg     (req_reg[p*5 +: 5]),
            .needNow    (req_need_now[p]),
            .gprData    (gprWord),
            .fwdData    (lkData),
            .fwdSrc     (lkSrc),
            .stallReq   (lkStall)
        );

`ifdef FWD_MEM_OVERRIDE_EN
        always_comb begin
            if (reset) begin
                fwd_data[p*DATA_W +: DATA_W] = gprWord;
                fwd_src[p*SRC_W +: SRC_W]    = SRC_W'(SRC_GPR);
                portStall[p]                 = 1'b0;
            end else if (mem_fwd_en[p]) begin
                fwd_data[p*DATA_W +: DATA_W] = mem_fwd_data[p*DATA_W +: DATA_W];
                fwd_src[p*SRC_W +: SRC_W]    = SRC_W'(DEPTH + 1);
                portStall[p]                 = 1'b0;
            end else begin
                fwd_data[p*DATA_W +: DATA_W] = lkData;
                fwd_src[p*SRC_W +: SRC_W]    = lkSrc;
                portStall[p]                 = lkStall;
            end
        end
`else
        always_comb begin
            if (reset) begin
                fwd_data[p*DATA_W +: DATA_W] = gprWord;
                fwd_src[p*SRC_W +: SRC_W]    = SRC_W'(SRC_GPR);
                portStall[p]                 = 1'b0;
            end else begin
                fwd_data[p*DATA_W +: DATA_W] = lkData;
                fwd_src[p*SRC_W +: SRC_W]    = lkSrc;
                portStall[p]                 = lkStall;
            end
        end
`endif
    end

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// tb/tb_forwarding_scoreboard.sv - scoreboard bench for forwarding_scoreboard (FWD_MEM_OVERRIDE_EN optional)
module tb_forwarding_scoreboard;

    localparam int NP = 2;
    localparam int DP = 3;
    localparam int DW = 32;
    localparam int SW = 3;

    localparam logic [31:0] RES0 = 32'hA000_00A0;
    localparam logic [31:0] RES1 = 32'hB000_00B1;
    localparam logic [31:0] RES2 = 32'hC000_00C2;
    localparam logic [31:0] GPR0 = 32'h1111_1111;
    localparam logic [31:0] GPR1 = 32'h2222_2222;

    logic              clock = 1'b0;
    logic              reset;
    logic              advance;
    logic              issue_valid;
    logic [4:0]        issue_wreg;
    logic [1:0]        issue_ready_stage;
    logic              flush;
    logic [DP*DW-1:0]  stage_result;
    logic [NP*5-1:0]   req_reg;
    logic [NP-1:0]     req_need_now;
    logic [NP*DW-1:0]  gpr_data;
    logic              mdu_start;
    logic [5:0]        mdu_cycles;
    logic              mdu_read;
    logic [NP*DW-1:0]  fwd_data;
    logic [NP*SW-1:0]  fwd_src;
    logic              stall;
    logic              mdu_busy;
`ifdef FWD_MEM_OVERRIDE_EN
    logic [NP-1:0]     mem_fwd_en;
    logic [NP*DW-1:0]  mem_fwd_data;
`endif

    always #5 clock = ~clock;

    forwarding_scoreboard #(.NUM_PORTS(NP), .DEPTH(DP), .DATA_W(DW)) dut (
        .clock            (clock),
        .reset            (reset),
        .advance          (advance),
        .issue_valid      (issue_valid),
        .issue_wreg       (issue_wreg),
        .issue_ready_stage(issue_ready_stage),
        .flush            (flush),
        .stage_result     (stage_result),
        .req_reg          (req_reg),
        .req_need_now     (req_need_now),
        .gpr_data         (gpr_data),
        .mdu_start        (mdu_start),
        .mdu_cycles       (mdu_cycles),
        .mdu_read         (mdu_read),
`ifdef FWD_MEM_OVERRIDE_EN
        .mem_fwd_en       (mem_fwd_en),
        .mem_fwd_data     (mem_fwd_data),
`endif
        .fwd_data         (fwd_data),
        .fwd_src          (fwd_src),
        .stall            (stall),
        .mdu_busy         (mdu_busy)
    );

    // kind: 0 = fwd_src[port], 1 = fwd_data[port], 2 = stall, 3 = mdu_busy
    typedef struct {
        string       name;
        int          kind;
        int          port;
        logic [31:0] expVal;
    } expect_t;

    expect_t expQ[$];
    int      checks = 0;
    int      errors = 0;

    task automatic push(input string name, input int kind, input int port, input logic [31:0] v);
        expect_t e;
        e.name = name; e.kind = kind; e.port = port; e.expVal = v;
        expQ.push_back(e);
    endtask

    task automatic expSrc(input string n, input int p, input int v);
        push(n, 0, p, 32'(v));
    endtask
    task automatic expData(input string n, input int p, input logic [31:0] v);
        push(n, 1, p, v);
    endtask
    task automatic expStall(input string n, input logic v);
        push(n, 2, 0, {31'd0, v});
    endtask
    task automatic expBusy(input string n, input logic v);
        push(n, 3, 0, {31'd0, v});
    endtask

    // Monitor: compares everything queued during the current cycle at the falling edge.
    initial begin
        forever begin
            @(negedge clock);
            while (expQ.size() > 0) begin
                expect_t     e;
                logic [31:0] act;
                e = expQ.pop_front();
                case (e.kind)
                    0:       act = 32'(fwd_src[e.port*SW +: SW]);
                    1:       act = fwd_data[e.port*DW +: DW];
                    2:       act = {31'd0, stall};
                    default: act = {31'd0, mdu_busy};
                endcase
                checks++;
                if (act !== e.expVal) begin
                    errors++;
                    $display("FAIL %s: got %0h expected %0h", e.name, act, e.expVal);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic setReq(input int p, input logic [4:0] r, input logic need);
        req_reg[p*5 +: 5] = r;
        req_need_now[p]   = need;
    endtask

    task automatic issue(input logic [4:0] w, input logic [1:0] rs);
        issue_valid = 1'b1; issue_wreg = w; issue_ready_stage = rs; advance = 1'b1;
    endtask

    task automatic idle();
        issue_valid = 1'b0; advance = 1'b0; flush = 1'b0; mdu_start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; advance = 1'b0; issue_valid = 1'b0; issue_wreg = '0;
        issue_ready_stage = '0; flush = 1'b0; mdu_start = 1'b0; mdu_cycles = '0; mdu_read = 1'b0;
        stage_result = {RES2, RES1, RES0};
        gpr_data = {GPR1, GPR0};
        req_reg = '0; req_need_now = '0;
`ifdef FWD_MEM_OVERRIDE_EN
        mem_fwd_en = '0; mem_fwd_data = {32'h0, 32'hDEAD_BEEF};
`endif
        step();
        mdu_read = 1'b1; setReq(0, 5'd8, 1'b1);
        expStall("rst_stall", 1'b0); expBusy("rst_busy", 1'b0);
        expSrc("rst_src", 0, 0); expData("rst_data", 0, GPR0);
        step();
        reset = 1'b0; mdu_read = 1'b0; setReq(0, 5'd0, 1'b0);

        // Ready-at-EX producer forwards from EX.
        issue(5'd8, 2'd0);
        step(); idle();
        setReq(0, 5'd8, 1'b1);
        expSrc("ex_src", 0, 1); expData("ex_data", 0, RES0); expStall("ex_stall", 1'b0);
        step(); setReq(0, 5'd0, 1'b0);

        // Load ready at MEM: stall in EX, forward from MEM after one advance.
        issue(5'd9, 2'd1);
        step(); idle();
        setReq(1, 5'd9, 1'b0);
        expStall("load_noneed", 1'b0); expSrc("load_src_ex", 1, 1);
        step();
        setReq(1, 5'd9, 1'b1);
        expStall("load_stall", 1'b1);
        step();
        advance = 1'b1;
        expStall("load_stall_adv", 1'b1);
        step(); idle();
        setReq(0, 5'd8, 1'b0);
        expSrc("load_src_mem", 1, 2); expData("load_data_mem", 1, RES1); expStall("load_ready", 1'b0);
        expSrc("old_src_wb", 0, 3); expData("old_data_wb", 0, RES2);
        step(); setReq(0, 5'd0, 1'b0); setReq(1, 5'd0, 1'b0);

        // Reset wins over a same-cycle issue and advance.
        reset = 1'b1; issue(5'd5, 2'd0);
        step(); reset = 1'b0; idle();
        setReq(0, 5'd5, 1'b0); setReq(1, 5'd9, 1'b0);
        expSrc("rst_prio_src", 0, 0); expSrc("rst_clear_src", 1, 0);
        step();

        // Priority: two producers of r5 at index 0 and 2.
        issue(5'd5, 2'd0); step();
        issue(5'd6, 2'd0); step();
        issue(5'd5, 2'd0); step(); idle();
        setReq(0, 5'd5, 1'b0); setReq(1, 5'd0, 1'b1);
        expSrc("prio_src", 0, 1); expData("prio_data", 0, RES0);
        expSrc("r0_src", 1, 0); expData("r0_data", 1, GPR1);
        step();
        setReq(1, 5'd6, 1'b0);
        expSrc("mid_src", 1, 2); expData("mid_data", 1, RES1);
        step();

        // Flush squashes the entering instruction; older entries shift.
        issue(5'd7, 2'd0); flush = 1'b1;
        step(); idle();
        setReq(0, 5'd7, 1'b0); setReq(1, 5'd5, 1'b0);
        expSrc("flush_src", 0, 0); expData("flush_data", 0, GPR0);
        expSrc("flush_shift_src", 1, 2);
        step();

        // No advance: issue is not captured.
        issue(5'd10, 2'd0); advance = 1'b0;
        step(); idle();
        setReq(0, 5'd10, 1'b0);
        expSrc("hold_src", 0, 0);
        step();

        // Ready at WB; a stalled issue becomes a bubble.
        setReq(0, 5'd0, 1'b0); setReq(1, 5'd0, 1'b0);
        issue(5'd12, 2'd2);
        step(); idle();
        setReq(0, 5'd12, 1'b1);
        expStall("wb_stall_ex", 1'b1); expSrc("wb_src_ex", 0, 1);
        advance = 1'b1;
        step();
        issue(5'd13, 2'd0);
        expStall("wb_stall_mem", 1'b1); expSrc("wb_src_mem", 0, 2); expData("wb_data_mem", 0, RES1);
        step(); idle();
        setReq(1, 5'd13, 1'b0);
        expStall("wb_ready", 1'b0); expSrc("wb_src_wb", 0, 3); expData("wb_data_wb", 0, RES2);
        expSrc("bubble_src", 1, 0);
        step(); setReq(0, 5'd0, 1'b0); setReq(1, 5'd0, 1'b0);

        // MDU: 4-cycle op with HI/LO read pending.
        mdu_start = 1'b1; mdu_cycles = 6'd4; mdu_read = 1'b1;
        expStall("mdu_pre", 1'b0); expBusy("mdu_pre_busy", 1'b0);
        step(); mdu_start = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            expStall($sformatf("mdu_stall_c%0d", c), 1'b1);
            expBusy($sformatf("mdu_busy_c%0d", c), 1'b1);
            step();
        end
        expStall("mdu_done", 1'b0); expBusy("mdu_done_busy", 1'b0);
        step();

        // Reload while busy, busy without read does not stall.
        mdu_start = 1'b1; mdu_cycles = 6'd4; mdu_read = 1'b0;
        step(); mdu_start = 1'b0;
        expStall("mdu_noread", 1'b0);
        step();
        mdu_start = 1'b1; mdu_cycles = 6'd2;
        step(); mdu_start = 1'b0;
        expBusy("reload_c1", 1'b1);
        step();
        expBusy("reload_c2", 1'b1);
        step();
        expBusy("reload_done", 1'b0);
        step();

        // Reset during an MDU op clears the counter.
        mdu_start = 1'b1; mdu_cycles = 6'd4; mdu_read = 1'b1;
        step(); mdu_start = 1'b0;
        step();
        reset = 1'b1;
        step(); reset = 1'b0;
        expBusy("mdu_rst_busy", 1'b0); expStall("mdu_rst_stall", 1'b0);
        step(); mdu_read = 1'b0;

`ifdef FWD_MEM_OVERRIDE_EN
        issue(5'd9, 2'd1);
        step(); idle();
        setReq(0, 5'd9, 1'b1); mem_fwd_en = 2'b01;
        expSrc("ovr_src", 0, DP + 1); expData("ovr_data", 0, 32'hDEAD_BEEF); expStall("ovr_stall", 1'b0);
        step(); mem_fwd_en = '0; setReq(0, 5'd0, 1'b0);
`endif

        repeat (2) @(posedge clock);
        #1;
        checks++;
        if (expQ.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending expected 0", expQ.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
